pcd_frame_decoder: RTL

// - PICC-side receiver for ISO 14443-A 106 kbit/s PCD->PICC frames: slices modified-Miller

---
 rtl/rfid_pkg.sv | 36 +++
 rtl/pcd_frame_decoder_if.sv | 43 ++++
 rtl/miller_symbol_slicer.sv | 32 +++
 rtl/pcd_frame_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// Shared types and helpers for the PCD->PICC modified-Miller receive path.
// Symbol set, frame constants and parity helper.
package rfid_pkg;

  typedef enum logic [1:0] {
    SYM_X,
    SYM_Y,
    SYM_Z,
    SYM_BAD
  } miller_sym_t;

  localparam int DEF_MAX_BYTES    = 5;
  localparam int SHORT_FRAME_BITS = 7;

  function automatic logic odd_parity_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

  // q[3] is the oldest quarter sample (q0)
  function automatic miller_sym_t classify_sym(
    input logic [3:0] q
  );
    miller_sym_t s;
    case (q)
      4'b1101: s = SYM_X;
      4'b0111: s = SYM_Z;
      4'b1111: s = SYM_Y;
      default: s = SYM_BAD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pcd_frame_decoder_if.sv
// Envelope-sample input and decoded-frame output bundle of the decoder.
// master = envelope source / frame consumer, slave = decoder.
interface pcd_frame_decoder_if
  import rfid_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES
);

  logic                   env_in;
  logic                   env_valid;
  logic [8*MAX_BYTES-1:0] data_out;
  logic [2:0]             num_bytes_out;
  logic                   short_frame_out;
  logic                   frame_valid;
  logic                   parity_err;
  logic                   coding_err;
  logic                   busy;

  modport master (
    output env_in,
    output env_valid,
    input  data_out,
    input  num_bytes_out,
    input  short_frame_out,
    input  frame_valid,
    input  parity_err,
    input  coding_err,
    input  busy
  );

  modport slave (
    input  env_in,
    input  env_valid,
    output data_out,
    output num_bytes_out,
    output short_frame_out,
    output frame_valid,
    output parity_err,
    output coding_err,
    output busy
  );

endinterface

// File: rtl/miller_symbol_slicer.sv
// Groups quarter-bit envelope samples into modified-Miller symbols.
// i_hold keeps the slicer realigned to the next start-bit pause.
module miller_symbol_slicer
  import rfid_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_valid,
  input  logic        i_env,
  output miller_sym_t o_sym,
  output logic        o_sym_valid
);

  logic [1:0] r_qcnt;
  logic [2:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_hold) begin
      r_qcnt <= 2'd0;
      r_sh   <= 3'd0;
    end else if (i_valid) begin
      r_qcnt <= r_qcnt + 2'd1;
      r_sh   <= {r_sh[1:0], i_env};
    end
  end

  // symbol completes combinationally on the q3 sample
  assign o_sym_valid = i_valid && !i_hold && (r_qcnt == 2'd3);
  assign o_sym       = classify_sym({r_sh, i_env});

endmodule

// File: rtl/pcd_frame_decoder.sv
// ISO 14443-A 106 kbit/s PCD->PICC frame receiver (Miller slice, parity, unpack).
// Define PCD_PARITY_CHECK_EN to report odd-parity failures on parity_err.
module pcd_frame_decoder
  import rfid_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES
)(
  input  logic                 clk_in,
  input  logic                 rst_in,
  pcd_frame_decoder_if.slave   bus
);

  localparam int BUF_BITS = 9*MAX_BYTES + 1;
  localparam int CW       = $clog2(BUF_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RX    = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

`ifdef PCD_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic [1:0]             r_state;
  logic [BUF_BITS-1:0]    r_bits;
  logic [CW-1:0]          r_cnt;
  logic                   r_prev;
  logic                   r_started;
  logic [2:0]             r_ones;
  logic [8*MAX_BYTES-1:0] r_data;
  logic [2:0]             r_nbytes;
  logic                   r_short;
  logic                   r_fv;
  logic                   r_perr;
  logic                   r_cerr;

  logic        w_hold;
  miller_sym_t w_sym;
  logic        w_sym_valid;
  logic        w_app;
  logic        w_bit;
  logic        w_end;
  logic        w_err;

  int                     w_plen;
  int                     w_nb;
  logic                   w_len_ok;
  logic                   w_short;
  logic                   w_perr;
  logic [8*MAX_BYTES-1:0] w_data;

  assign w_hold = (r_state == S_IDLE) &&
                  !(bus.env_valid && !bus.env_in);

  miller_symbol_slicer u_slicer (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_hold      (w_hold),
    .i_valid     (bus.env_valid),
    .i_env       (bus.env_in),
    .o_sym       (w_sym),
    .o_sym_valid (w_sym_valid)
  );

  always_comb begin
    w_app = 1'b0;
    w_bit = 1'b0;
    w_end = 1'b0;
    w_err = 1'b0;
    if (r_state == S_RX && w_sym_valid) begin
      if (!r_started) begin
        w_err = (w_sym != SYM_Z);
      end else begin
        unique case (w_sym)
          SYM_X: begin
            w_app = 1'b1;
            w_bit = 1'b1;
          end
          SYM_Z: w_app = 1'b1;
          SYM_Y: begin
            if (r_prev) w_app = 1'b1;
            else        w_end = 1'b1;
          end
          default: w_err = 1'b1;
        endcase
      end
      if (w_app && r_cnt == CW'(BUF_BITS)) begin
        w_app = 1'b0;
        w_err = 1'b1;
      end
    end
  end

  // payload excludes the trailing end-of-communication 0
  always_comb begin
    w_plen   = int'(r_cnt) - 1;
    w_nb     = 0;
    w_len_ok = 1'b0;
    w_short  = 1'b0;
    w_perr   = 1'b0;
    w_data   = '0;
    if (w_plen == SHORT_FRAME_BITS) begin
      w_len_ok    = 1'b1;
      w_short     = 1'b1;
      w_data[6:0] = r_bits[6:0];
    end
    for (int k = 1; k <= MAX_BYTES; k++) begin
      if (w_plen == 9*k) begin
        w_len_ok = 1'b1;
        w_nb     = k;
      end
    end
    for (int j = 0; j < MAX_BYTES; j++) begin
      if (j < w_nb) begin
        w_data[8*j +: 8] = r_bits[9*j +: 8];
        if (!odd_parity_ok(r_bits[9*j +: 8], r_bits[9*j+8]))
          w_perr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_bits    <= '0;
      r_cnt     <= '0;
      r_prev    <= 1'b0;
      r_started <= 1'b0;
      r_ones    <= 3'd0;
      r_data    <= '0;
      r_nbytes  <= 3'd0;
      r_short   <= 1'b0;
      r_fv      <= 1'b0;
      r_perr    <= 1'b0;
      r_cerr    <= 1'b0;
    end else begin
      r_fv   <= 1'b0;
      r_perr <= 1'b0;
      r_cerr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.env_valid && !bus.env_in) begin
            r_state   <= S_RX;
            r_bits    <= '0;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_started <= 1'b0;
          end
        end
        S_RX: begin
          if (w_sym_valid) r_started <= 1'b1;
          if (w_app) begin
            r_bits[r_cnt] <= w_bit;
            r_cnt         <= r_cnt + 1'b1;
            r_prev        <= w_bit;
          end
          if (w_err) begin
            r_cerr  <= 1'b1;
            r_ones  <= 3'd0;
            r_state <= S_FLUSH;
          end
          if (w_end) begin
            r_state <= S_IDLE;
            if (w_len_ok) begin
              r_fv     <= 1'b1;
              r_perr   <= w_perr & PARITY_EN;
              r_data   <= w_data;
              r_nbytes <= 3'(w_nb);
              r_short  <= w_short;
            end else if (w_plen != 0) begin
              r_cerr <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (bus.env_valid) begin
            if (!bus.env_in)         r_ones  <= 3'd0;
            else if (r_ones == 3'd7) r_state <= S_IDLE;
            else                     r_ones  <= r_ones + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out        = r_data;
  assign bus.num_bytes_out   = r_nbytes;
  assign bus.short_frame_out = r_short;
  assign bus.frame_valid     = r_fv;
  assign bus.parity_err      = r_perr;
  assign bus.coding_err      = r_cerr;
  assign bus.busy            = (r_state != S_IDLE);

endmodule
